// File: rtl/on_the_fly_node_to_noc_pkg.sv
// Shared definitions for the node->NoC pending-transaction table.
// Holds the NIC field widths, the table depth, a clog2 helper and the
// table entry type (valid bit plus sender/recipient/type tuple).
package on_the_fly_node_to_noc_pkg;

    localparam int unsigned TABLE_PENDING_NODE2NOC_WIDTH  = 8;
    localparam int unsigned BUS_ADDRESS_WIDTH             = 4;
    localparam int unsigned N_BITS_COHERENCE_MESSAGE_TYPE = 3;

    // Ceiling log2, never below 1 so a one-slot table still has an index bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef struct packed {
        logic                                     valid;
        logic [BUS_ADDRESS_WIDTH-1:0]             sender;
        logic [BUS_ADDRESS_WIDTH-1:0]             recipient;
        logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] msg_type;
    } pending_entry_t;

endpackage

// File: rtl/on_the_fly_node_to_noc_lowest_set_index.sv
// Priority encoder: reports the index of the lowest set bit of vec.
// Ports:
//   vec   - input vector, 2**N_BITS_POINTER bits
//   index - index of the lowest set bit (0 when none is set)
//   found - at least one bit of vec is set
module on_the_fly_node_to_noc_lowest_set_index #(
    parameter int unsigned N_BITS_POINTER = 3
) (
    input  logic [(1 << N_BITS_POINTER)-1:0] vec,
    output logic [N_BITS_POINTER-1:0]        index,
    output logic                             found
);

    localparam int unsigned Width = 1 << N_BITS_POINTER;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = N_BITS_POINTER'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/on_the_fly_node_to_noc.sv
// Pending-transaction table on the node->NoC path.
// Records (sender, recipient, type) tuples of outstanding requests and
// answers combinational lookups, optionally retiring one matching entry.
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   new_pending_transaction_i  - insert the new_* tuple this cycle
//   new_sender_i / new_recipient_i / new_transaction_type_i - tuple to insert
//   query_i                    - lookup request
//   query_sender_i / query_recipient_i / query_transaction_type_i - lookup key
//   delete_transaction_i       - retire the lowest matching entry (with query_i)
//   is_a_pending_transaction_o - query_i and some valid entry matches the key
module on_the_fly_node_to_noc
    import on_the_fly_node_to_noc_pkg::*;
#(
    parameter int unsigned N_BITS_POINTER = clog2(TABLE_PENDING_NODE2NOC_WIDTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     new_pending_transaction_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]             new_sender_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]             new_recipient_i,
    input  logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] new_transaction_type_i,
    input  logic                                     query_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]             query_sender_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]             query_recipient_i,
    input  logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] query_transaction_type_i,
    input  logic                                     delete_transaction_i,
    output logic                                     is_a_pending_transaction_o
);

    localparam int unsigned Depth    = TABLE_PENDING_NODE2NOC_WIDTH;
    localparam int unsigned EncWidth = 1 << N_BITS_POINTER;

    pending_entry_t table_q [Depth];

    logic [EncWidth-1:0]       free_vec;
    logic [EncWidth-1:0]       hit_vec;
    logic [N_BITS_POINTER-1:0] free_idx;
    logic [N_BITS_POINTER-1:0] hit_idx;
    logic                      free_found;
    logic                      hit_found;
    logic                      do_insert;
    logic                      do_delete;

    // Encoder bits beyond the table depth stay 0: never free, never hit.
    always_comb begin
        free_vec = '0;
        hit_vec  = '0;
        for (int i = 0; i < Depth; i++) begin
            free_vec[i] = ~table_q[i].valid;
            hit_vec[i]  = table_q[i].valid
                       && (table_q[i].sender    == query_sender_i)
                       && (table_q[i].recipient == query_recipient_i)
                       && (table_q[i].msg_type  == query_transaction_type_i);
        end
    end

    on_the_fly_node_to_noc_lowest_set_index #(
        .N_BITS_POINTER(N_BITS_POINTER)
    ) u_free_sel (
        .vec  (free_vec),
        .index(free_idx),
        .found(free_found)
    );

    on_the_fly_node_to_noc_lowest_set_index #(
        .N_BITS_POINTER(N_BITS_POINTER)
    ) u_hit_sel (
        .vec  (hit_vec),
        .index(hit_idx),
        .found(hit_found)
    );

    assign is_a_pending_transaction_o = query_i && hit_found;

    // A full table silently drops the insert.
    assign do_insert = new_pending_transaction_i && free_found;
    assign do_delete = query_i && delete_transaction_i && hit_found;

    // Free slots are invalid and hit slots are valid, so an insert and a
    // delete in the same cycle always target different slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (do_insert && (free_idx == N_BITS_POINTER'(i))) begin
                    table_q[i].valid     <= 1'b1;
                    table_q[i].sender    <= new_sender_i;
                    table_q[i].recipient <= new_recipient_i;
                    table_q[i].msg_type  <= new_transaction_type_i;
                end else if (do_delete && (hit_idx == N_BITS_POINTER'(i))) begin
                    table_q[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_on_the_fly_node_to_noc.sv
// Self-checking bench for the pending-transaction table. The reference model
// is a bounded multiset (queue) of tuples: insert appends when fewer than
// Depth tuples are held before the edge, delete removes one equal tuple.
module tb_on_the_fly_node_to_noc;
    import on_the_fly_node_to_noc_pkg::*;

    localparam int unsigned Depth = TABLE_PENDING_NODE2NOC_WIDTH;
    localparam int unsigned AW    = BUS_ADDRESS_WIDTH;
    localparam int unsigned TW    = N_BITS_COHERENCE_MESSAGE_TYPE;

    typedef logic [2*AW+TW-1:0] key_t;

    logic          clk;
    logic          rst;
    logic          new_pending_transaction_i;
    logic [AW-1:0] new_sender_i;
    logic [AW-1:0] new_recipient_i;
    logic [TW-1:0] new_transaction_type_i;
    logic          query_i;
    logic [AW-1:0] query_sender_i;
    logic [AW-1:0] query_recipient_i;
    logic [TW-1:0] query_transaction_type_i;
    logic          delete_transaction_i;
    logic          is_a_pending_transaction_o;

    int checks = 0;
    int errors = 0;

    key_t model_q[$];

    on_the_fly_node_to_noc dut (
        .clk                       (clk),
        .rst                       (rst),
        .new_pending_transaction_i (new_pending_transaction_i),
        .new_sender_i              (new_sender_i),
        .new_recipient_i           (new_recipient_i),
        .new_transaction_type_i    (new_transaction_type_i),
        .query_i                   (query_i),
        .query_sender_i            (query_sender_i),
        .query_recipient_i         (query_recipient_i),
        .query_transaction_type_i  (query_transaction_type_i),
        .delete_transaction_i      (delete_transaction_i),
        .is_a_pending_transaction_o(is_a_pending_transaction_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic key_t mk_key(input int unsigned s, input int unsigned r,
                                    input int unsigned t);
        return {AW'(s), AW'(r), TW'(t)};
    endfunction

    function automatic logic model_hit(input key_t k);
        foreach (model_q[i]) begin
            if (model_q[i] == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_idle();
        new_pending_transaction_i = 1'b0;
        new_sender_i              = '0;
        new_recipient_i           = '0;
        new_transaction_type_i    = '0;
        query_i                   = 1'b0;
        query_sender_i            = '0;
        query_recipient_i         = '0;
        query_transaction_type_i  = '0;
        delete_transaction_i      = 1'b0;
    endtask

    // Drives one cycle starting just after a rising edge, samples the output
    // mid-cycle, then advances the reference model across the edge.
    task automatic do_cycle(input bit ins, input int unsigned ns, input int unsigned nr,
                            input int unsigned nt, input bit q, input int unsigned qs,
                            input int unsigned qr, input int unsigned qt, input bit del,
                            output logic obs, output logic exp);
        key_t qk;
        key_t nk;
        int   pre_size;
        new_pending_transaction_i = ins;
        new_sender_i              = AW'(ns);
        new_recipient_i           = AW'(nr);
        new_transaction_type_i    = TW'(nt);
        query_i                   = q;
        query_sender_i            = AW'(qs);
        query_recipient_i         = AW'(qr);
        query_transaction_type_i  = TW'(qt);
        delete_transaction_i      = del;
        qk = mk_key(qs, qr, qt);
        nk = mk_key(ns, nr, nt);
        #4;
        obs      = is_a_pending_transaction_o;
        exp      = q && model_hit(qk);
        pre_size = model_q.size();
        @(posedge clk);
        if (q && del) begin
            for (int i = 0; i < model_q.size(); i++) begin
                if (model_q[i] == qk) begin
                    model_q.delete(i);
                    break;
                end
            end
        end
        if (ins && pre_size < int'(Depth)) model_q.push_back(nk);
        #1;
        drive_idle();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_q.delete();
    endtask

    task automatic test_reset();
        logic obs, exp;
        drive_idle();
        rst = 1'b0;
        query_i = 1'b1;
        query_sender_i = AW'(1);
        query_recipient_i = AW'(2);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (is_a_pending_transaction_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out=%b want 0", is_a_pending_transaction_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_q.delete();
        do_cycle(0, 0, 0, 0, 1, 1, 2, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL reset_query: out=%b want 0", obs);
        end
    endtask

    task automatic test_insert_hit();
        logic obs, exp;
        do_cycle(1, 1, 2, 0, 0, 0, 0, 0, 0, obs, exp);
        do_cycle(0, 0, 0, 0, 1, 1, 2, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL hit_120: out=%b want 1", obs); end
        do_cycle(0, 0, 0, 0, 1, 1, 3, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL miss_130: out=%b want 0", obs); end
        do_cycle(0, 0, 0, 0, 1, 1, 2, 1, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL miss_121: out=%b want 0", obs); end
    endtask

    task automatic test_delete_concurrent();
        logic obs, exp;
        do_cycle(1, 2, 2, 0, 1, 1, 2, 0, 1, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL del_cycle: out=%b want 1", obs); end
        do_cycle(1, 3, 2, 0, 1, 1, 2, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL after_del: out=%b want 0", obs); end
        do_cycle(0, 0, 0, 0, 1, 3, 2, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL hit_320: out=%b want 1", obs); end
        do_cycle(0, 0, 0, 0, 1, 2, 2, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL hit_220: out=%b want 1", obs); end
    endtask

    task automatic test_same_cycle();
        logic obs, exp;
        do_cycle(1, 5, 5, 1, 1, 5, 5, 1, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL no_bypass: out=%b want 0", obs); end
        do_cycle(0, 0, 0, 0, 1, 5, 5, 1, 0, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL next_hit: out=%b want 1", obs); end
    endtask

    task automatic test_fill_overflow();
        logic obs, exp;
        apply_reset();
        for (int i = 0; i < int'(Depth); i++) begin
            do_cycle(1, i, 8, 2, 0, 0, 0, 0, 0, obs, exp);
        end
        do_cycle(1, 7, 7, 0, 0, 0, 0, 0, 0, obs, exp);
        do_cycle(0, 0, 0, 0, 1, 7, 7, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL overflow_drop: out=%b want 0", obs); end
        for (int i = 0; i < int'(Depth); i++) begin
            do_cycle(0, 0, 0, 0, 1, i, 8, 2, 0, obs, exp);
            checks++;
            if (obs !== 1'b1) begin
                errors++;
                $display("FAIL fill_keep[%0d]: out=%b want 1", i, obs);
            end
        end
        // Full before the edge, so the concurrent insert is dropped.
        do_cycle(1, 7, 7, 0, 1, 3, 8, 2, 1, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL full_del: out=%b want 1", obs); end
        do_cycle(0, 0, 0, 0, 1, 7, 7, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL full_concur_drop: out=%b want 0", obs); end
        do_cycle(0, 0, 0, 0, 1, 3, 8, 2, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL deleted_gone: out=%b want 0", obs); end
        do_cycle(1, 7, 7, 0, 0, 0, 0, 0, 0, obs, exp);
        do_cycle(0, 0, 0, 0, 1, 7, 7, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL slot_reuse: out=%b want 1", obs); end
        do_cycle(1, 6, 6, 6, 0, 0, 0, 0, 0, obs, exp);
        do_cycle(0, 0, 0, 0, 1, 6, 6, 6, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL refull_drop: out=%b want 0", obs); end
    endtask

    task automatic test_duplicates();
        logic obs, exp;
        apply_reset();
        do_cycle(1, 4, 4, 0, 0, 0, 0, 0, 0, obs, exp);
        do_cycle(1, 4, 4, 0, 0, 0, 0, 0, 0, obs, exp);
        do_cycle(0, 0, 0, 0, 1, 4, 4, 0, 1, obs, exp);
        do_cycle(0, 0, 0, 0, 1, 4, 4, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL dup_one_left: out=%b want 1", obs); end
        do_cycle(0, 0, 0, 0, 1, 4, 4, 0, 1, obs, exp);
        do_cycle(0, 0, 0, 0, 1, 4, 4, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL dup_none_left: out=%b want 0", obs); end
        do_cycle(1, 4, 4, 0, 0, 0, 0, 0, 0, obs, exp);
        do_cycle(0, 0, 0, 0, 0, 4, 4, 0, 1, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL noquery_out: out=%b want 0", obs); end
        do_cycle(0, 0, 0, 0, 1, 4, 4, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b1) begin errors++; $display("FAIL noquery_del: out=%b want 1", obs); end
    endtask

    task automatic test_reset_mid();
        logic obs, exp;
        do_cycle(1, 9, 9, 1, 0, 0, 0, 0, 0, obs, exp);
        new_pending_transaction_i = 1'b1;
        new_sender_i              = AW'(10);
        new_recipient_i           = AW'(10);
        new_transaction_type_i    = TW'(1);
        query_i                   = 1'b1;
        query_sender_i            = AW'(4);
        query_recipient_i         = AW'(4);
        delete_transaction_i      = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (is_a_pending_transaction_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out: out=%b want 0", is_a_pending_transaction_o);
        end
        @(posedge clk);
        #1;
        drive_idle();
        model_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_cycle(0, 0, 0, 0, 1, 9, 9, 1, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL mid_reset_9: out=%b want 0", obs); end
        do_cycle(0, 0, 0, 0, 1, 10, 10, 1, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL mid_reset_ins: out=%b want 0", obs); end
        do_cycle(0, 0, 0, 0, 1, 4, 4, 0, 0, obs, exp);
        checks++;
        if (obs !== 1'b0) begin errors++; $display("FAIL mid_reset_4: out=%b want 0", obs); end
    endtask

    task automatic test_random();
        logic obs, exp;
        bit   ins, q, del;
        int unsigned ns, nr, nt, qs, qr, qt;
        for (int n = 0; n < 400; n++) begin
            ins = ($urandom_range(0, 1) == 1);
            q   = ($urandom_range(0, 3) != 0);
            del = ($urandom_range(0, 2) == 0);
            ns  = $urandom_range(0, 3);
            nr  = $urandom_range(0, 3);
            nt  = $urandom_range(0, 1);
            qs  = $urandom_range(0, 3);
            qr  = $urandom_range(0, 3);
            qt  = $urandom_range(0, 1);
            do_cycle(ins, ns, nr, nt, q, qs, qr, qt, del, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random[%0d] key=(%0d,%0d,%0d): out=%b want %b",
                         n, qs, qr, qt, obs, exp);
            end
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        #1;
        test_reset();
        test_insert_hit();
        test_delete_concurrent();
        test_same_cycle();
        test_fill_overflow();
        test_duplicates();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
